hazard_ctrl: RTL

Pipeline stall/flush controller for the 5-stage RISC-V core; the stalling counterpart to the forwarding unit. It covers the hazards forwarding cannot fix:
- load-use dependencies, with a one-cycle bubble;
- taken branches and jumps resolved in EX, with an IF/ID + ID/EX squash;
- data-memory wait states, with a full freeze and a timeout watchdog.

It drives the enable/flush pins of every pipeline register and keeps saturating performance counters.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/sat_counter.sv | 27 ++
 rtl/hazard_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and defaults for the pipeline hazard controller.
//   hz_state_t          : memory-wait FSM states (RUN, WAIT, ERR)
//   HZ_TIMEOUT_DEFAULT  : default max consecutive data-memory wait cycles
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } hz_state_t;

    localparam int unsigned HZ_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the hazard performance counters.
// Ports:
//   clk   in   rising-edge clock
//   reset in   synchronous active-high clear
//   inc   in   count enable for this cycle
//   cnt   out  W-bit count, sticks at all-ones
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Stall/flush controller for the 5-stage pipeline: load-use bubble, EX-resolved
// branch squash, and data-memory wait freeze with a timeout watchdog.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   rs1_id, rs2_id              ID source registers
//   use_rs1_id, use_rs2_id      ID instruction really reads rs1 / rs2
//   rd_ex, memread_ex           EX destination register / EX is a load
//   branch_taken_ex             PC redirect resolved in EX
//   dmem_req_mem, dmem_ready    MEM access active / access completes
//   pc_en .. ex_mem_en          pipeline register load enables
//   if_id_flush .. mem_wb_flush insert bubble on next edge
//   mem_err                     sticky data-memory timeout flag
//   stall_cycles, flush_events  saturating performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned TIMEOUT = HZ_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             use_rs1_id,
    input  logic             use_rs2_id,
    input  logic [4:0]       rd_ex,
    input  logic             memread_ex,
    input  logic             branch_taken_ex,
    input  logic             dmem_req_mem,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int unsigned      WC_W    = $clog2(TIMEOUT) + 1;
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(TIMEOUT - 1);

    hz_state_t       state, state_nxt;
    logic [WC_W-1:0] wait_cnt;
    logic            mem_err_q;
    logic            freeze;
    logic            load_use;
    logic            stall_inc;
    logic            flush_inc;

    // wait_cnt counts every frozen memory cycle including the RUN cycle that
    // first saw the miss, so it holds TIMEOUT-1 on the TIMEOUT-th wait cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (state_nxt == ERR) begin
                mem_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        freeze       = 1'b0;
        load_use     = 1'b0;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;

        case (state)
            RUN: begin
                if (dmem_req_mem && !dmem_ready) begin
                    state_nxt = (TIMEOUT <= 1) ? ERR : WAIT;
                end
            end
            WAIT: begin
                if (dmem_ready) begin
                    state_nxt = RUN;
                end else if (wait_cnt == WC_LAST) begin
                    state_nxt = ERR;
                end
            end
            ERR:     state_nxt = ERR;
            default: state_nxt = RUN;
        endcase

        freeze = ((state == RUN) && dmem_req_mem && !dmem_ready)
               || ((state == WAIT) && !dmem_ready)
               || (state == ERR);

        load_use = memread_ex && (rd_ex != 5'd0)
                 && ((use_rs1_id && (rd_ex == rs1_id))
                  || (use_rs2_id && (rd_ex == rs2_id)));

        if (reset) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (freeze) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (branch_taken_ex) begin
            // ID instruction is squashed, so any load-use on it is moot.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    assign stall_inc = !reset && !pc_en;
    assign flush_inc = !reset && !freeze && branch_taken_ex;
    assign mem_err   = mem_err_q && !reset;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .cnt   (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .cnt   (flush_events)
    );

endmodule
